// File: rtl/battleship_pkg.sv
// Shared types and constants for the battleship input front end.
// Holds the debouncer state encoding, coordinate width and a busy helper.
package battleship_pkg;

  localparam int COORD_W = 2;

  typedef enum logic [2:0] {
    LOCKOUT      = 3'd0,
    IDLE         = 3'd1,
    PRESS_WAIT   = 3'd2,
    PRESSED      = 3'd3,
    RELEASE_WAIT = 3'd4
  } db_state_e;

  // A debouncer is busy while a press is in flight or being released.
  function automatic logic db_busy(db_state_e s);
    return !((s == IDLE) || (s == LOCKOUT));
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronizer plus debounce FSM for one button; one-cycle pulse per press.
// Ports: clk, rst (async high), btn_i raw, pulse_o press pulse, busy_o.
module btn_debounce
  import battleship_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o,
  output logic busy_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   smp;

  db_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_inc;
  logic            pulse_q, pulse_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
    end
  end

  assign smp = sync_q[SYNC_STAGES-1];

  // Saturating increment: the counter never wraps.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    unique case (state_q)
      LOCKOUT: begin
        if (smp) begin
          cnt_d = '0;
        end else if (cnt_inc == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      IDLE: begin
        if (smp) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!smp) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_inc == CNT_MAX) begin
          state_d = PRESSED;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      PRESSED: begin
        if (!smp) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (smp) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_inc == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = LOCKOUT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOCKOUT;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;
  assign busy_o  = db_busy(state_q);

endmodule

// File: rtl/battleship_input_ctrl.sv
// Button/switch conditioner feeding the battleship game FSM.
// Ports: raw start_btn/btn_a/btn_b/sw_x/sw_y in; start/pAb/pBb pulses, X/Y out.
module battleship_input_ctrl
  import battleship_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_btn,
  input  logic               btn_a,
  input  logic               btn_b,
  input  logic [COORD_W-1:0] sw_x,
  input  logic [COORD_W-1:0] sw_y,
  output logic               start,
  output logic               pAb,
  output logic               pBb,
  output logic [COORD_W-1:0] X,
  output logic [COORD_W-1:0] Y
);

  localparam int XYW = 2 * COORD_W;

  logic fire_s, fire_a, fire_b;
  logic busy_s, busy_a, busy_b;

  logic [SYNC_STAGES-1:0][XYW-1:0] sw_sync_q;

  logic           start_q, start_d;
  logic           pa_q, pa_d;
  logic           pb_q, pb_d;
  logic           pend_q, pend_d;
  logic [XYW-1:0] xy_q, xy_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_db_start (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (start_btn),
    .pulse_o(fire_s),
    .busy_o (busy_s)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_db_a (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (btn_a),
    .pulse_o(fire_a),
    .busy_o (busy_a)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_db_b (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (btn_b),
    .pulse_o(fire_b),
    .busy_o (busy_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_sync_q <= '0;
    end else begin
      sw_sync_q <= {sw_sync_q[SYNC_STAGES-2:0], {sw_x, sw_y}};
    end
  end

  // A wins a same-cycle collision; B is parked in pend_q and
  // issued on the next cycle A is quiet.
  always_comb begin
    start_d = fire_s;
    pa_d    = fire_a;
    pb_d    = 1'b0;
    pend_d  = pend_q;
    if (fire_a) begin
      pend_d = pend_q | fire_b;
    end else if (fire_b || pend_q) begin
      pb_d   = 1'b1;
      pend_d = fire_b & pend_q;
    end
  end

  // Coordinates track the switches only while no press is in flight.
  always_comb begin
    xy_d = xy_q;
    if (!(busy_a || busy_b || pend_q)) begin
      xy_d = sw_sync_q[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= 1'b0;
      pa_q    <= 1'b0;
      pb_q    <= 1'b0;
      pend_q  <= 1'b0;
      xy_q    <= '0;
    end else begin
      start_q <= start_d;
      pa_q    <= pa_d;
      pb_q    <= pb_d;
      pend_q  <= pend_d;
      xy_q    <= xy_d;
    end
  end

  assign start = start_q;
  assign pAb   = pa_q;
  assign pBb   = pb_q;
  assign X     = xy_q[XYW-1:COORD_W];
  assign Y     = xy_q[COORD_W-1:0];

endmodule

// File: tb/tb_battleship_input_ctrl.sv
// Scoreboard bench for battleship_input_ctrl.
// Stimulus pushes expected pulses; a monitor pops them as the DUT fires.
module tb_battleship_input_ctrl;

  localparam int DB = 16;
  localparam int SS = 2;
  localparam int LAT = DB + SS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_btn = 1'b0;
  logic       btn_a = 1'b0;
  logic       btn_b = 1'b0;
  logic [1:0] sw_x = 2'd1;
  logic [1:0] sw_y = 2'd2;
  logic       start, pAb, pBb;
  logic [1:0] X, Y;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    int kind;
    int cyc;
    int x;
    int y;
  } exp_t;

  exp_t q[$];

  battleship_input_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .SYNC_STAGES    (SS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start_btn(start_btn),
    .btn_a    (btn_a),
    .btn_b    (btn_b),
    .sw_x     (sw_x),
    .sw_y     (sw_y),
    .start    (start),
    .pAb      (pAb),
    .pBb      (pBb),
    .X        (X),
    .Y        (Y)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic expect_pulse(int kind, int c, int x, int y);
    exp_t e;
    e.kind = kind;
    e.cyc  = c;
    e.x    = x;
    e.y    = y;
    q.push_back(e);
  endtask

  task automatic take(int kind);
    exp_t e;
    if (q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_pulse: kind %0d at cycle %0d, none expected",
               kind, cyc);
    end else begin
      e = q.pop_front();
      chk("pulse_kind", kind, e.kind);
      chk("pulse_cycle", cyc, e.cyc);
      chk("pulse_xy", int'({X, Y}), e.x * 4 + e.y);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (start) take(0);
      if (pAb) take(1);
      if (pBb) take(2);
      if (pAb || pBb) chk("a_b_exclusive", int'(pAb & pBb), 0);
    end
  end

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_outs(string nm);
    chk({nm, "_start"}, int'(start), 0);
    chk({nm, "_pAb"}, int'(pAb), 0);
    chk({nm, "_pBb"}, int'(pBb), 0);
    chk({nm, "_X"}, int'(X), 0);
    chk({nm, "_Y"}, int'(Y), 0);
  endtask

  int t;
  int r;

  initial begin
    // Reset with buttons low.
    idle(3);
    chk_reset_outs("rst0");
    rst = 1'b0;
    idle(20);
    chk("idle_X", int'(X), 1);
    chk("idle_Y", int'(Y), 2);

    // Single clean press of A.
    btn_a = 1'b1;
    t = cyc + 1;
    expect_pulse(1, t + LAT, 1, 2);
    idle(30);
    btn_a = 1'b0;
    idle(30);

    // Long hold, release, re-press: two pulses only.
    btn_a = 1'b1;
    t = cyc + 1;
    expect_pulse(1, t + LAT, 1, 2);
    idle(200);
    btn_a = 1'b0;
    idle(30);
    btn_a = 1'b1;
    t = cyc + 1;
    expect_pulse(1, t + LAT, 1, 2);
    idle(30);
    btn_a = 1'b0;
    idle(30);

    // Bouncing B: high 5, low 1, high 20.
    sw_x = 2'd0;
    sw_y = 2'd3;
    idle(5);
    btn_b = 1'b1;
    idle(5);
    btn_b = 1'b0;
    idle(1);
    btn_b = 1'b1;
    t = cyc + 1;
    expect_pulse(2, t + LAT, 0, 3);
    idle(20);
    btn_b = 1'b0;
    idle(30);

    // Start press, independent of A/B.
    start_btn = 1'b1;
    t = cyc + 1;
    expect_pulse(0, t + LAT, 0, 3);
    idle(25);
    start_btn = 1'b0;
    idle(30);

    // A and B together: A first, B one cycle later.
    sw_x = 2'd3;
    sw_y = 2'd0;
    idle(5);
    btn_a = 1'b1;
    btn_b = 1'b1;
    t = cyc + 1;
    expect_pulse(1, t + LAT, 3, 0);
    expect_pulse(2, t + LAT + 1, 3, 0);
    idle(30);
    btn_a = 1'b0;
    btn_b = 1'b0;
    idle(30);

    // Coordinate freeze across a press and its release.
    sw_x = 2'd2;
    sw_y = 2'd1;
    idle(5);
    btn_a = 1'b1;
    t = cyc + 1;
    expect_pulse(1, t + LAT, 2, 1);
    idle(5);
    sw_x = 2'd3;
    sw_y = 2'd3;
    idle(25);
    chk("freeze_hold_X", int'(X), 2);
    chk("freeze_hold_Y", int'(Y), 1);
    @(negedge clk);
    btn_a = 1'b0;
    r = cyc + 1;
    wait_cyc(r + LAT - 1);
    chk("freeze_last_X", int'(X), 2);
    wait_cyc(r + LAT);
    chk("thaw_X", int'(X), 3);
    chk("thaw_Y", int'(Y), 3);
    idle(10);

    // Reset in mid-PRESS_WAIT with A still held.
    btn_a = 1'b1;
    idle(8);
    rst = 1'b1;
    #1;
    chk_reset_outs("rst_mid");
    idle(3);
    chk_reset_outs("rst_hold");
    rst = 1'b0;
    idle(40);
    btn_a = 1'b0;
    idle(40);
    btn_a = 1'b1;
    t = cyc + 1;
    expect_pulse(1, t + LAT, 3, 3);
    idle(30);
    btn_a = 1'b0;
    idle(40);

    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
